fan_speed: RTL and testbench

- Fixed-frequency PWM generator that drives a fan from an 8-bit speed command.
- Duty cycle is speed/256 and the PWM period is 256 clock cycles.
- A new command is applied only at a period boundary, so no runt or glitch pulses reach the fan driver.
- Sits between the fan-control logic (the speed source) and the fan driver pin.

---
 rtl/fan_speed_pkg.sv | 12 +
 rtl/fan_speed_if.sv | 14 +
 rtl/fan_speed_pwm_period_counter.sv | 25 ++
 rtl/fan_speed.sv | 48 ++++
 tb/tb_fan_speed.sv | 202 ++++++++++++++++++++
 5 files changed

// File: rtl/fan_speed_pkg.sv
// Shared constants and types for the fan PWM generator.
package fan_speed_pkg;

  localparam int unsigned PWM_WIDTH  = 8;
  localparam int unsigned PWM_PERIOD = 2 ** PWM_WIDTH;

  typedef logic [PWM_WIDTH-1:0] speed_t;

  localparam speed_t SPEED_OFF = PWM_WIDTH'(0);
  localparam speed_t SPEED_MAX = PWM_WIDTH'(PWM_PERIOD - 1);

endpackage : fan_speed_pkg

// File: rtl/fan_speed_if.sv
// Speed command in, PWM pin out: fan-control side is master, PWM block is slave.
interface fan_speed_if
  import fan_speed_pkg::*;
#(
  parameter int unsigned WIDTH = PWM_WIDTH
);

  logic [WIDTH-1:0] speed;
  logic             pwm_data;

  modport master (output speed, input pwm_data);
  modport slave  (input speed, output pwm_data);

endinterface : fan_speed_if

// File: rtl/fan_speed_pwm_period_counter.sv
// Free-running period counter; resets to all ones so the first edge starts period 0.
module fan_speed_pwm_period_counter
  import fan_speed_pkg::*;
#(
  parameter int unsigned WIDTH = PWM_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  output logic [WIDTH-1:0] cnt,
  output logic [WIDTH-1:0] next_cnt_c,
  output logic             wrap_c
);

  assign next_cnt_c = cnt + WIDTH'(1);
  assign wrap_c     = (next_cnt_c == '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '1;
    end else begin
      cnt <= next_cnt_c;
    end
  end

endmodule : fan_speed_pwm_period_counter

// File: rtl/fan_speed.sv
// Left-aligned PWM of period 2^WIDTH; speed is shadowed only at the period wrap.
module fan_speed
  import fan_speed_pkg::*;
#(
  parameter int unsigned WIDTH = PWM_WIDTH
) (
  input  logic              clk,
  input  logic              arst,
  fan_speed_if.slave        bus
);

  logic [WIDTH-1:0] cnt;
  logic [WIDTH-1:0] next_cnt_c;
  logic             wrap_c;
  logic [WIDTH-1:0] duty;
  logic [WIDTH-1:0] next_duty_c;
  logic             pwm_q;

  fan_speed_pwm_period_counter #(
    .WIDTH (WIDTH)
  ) u_counter (
    .clk        (clk),
    .rst_n      (arst),
    .cnt        (cnt),
    .next_cnt_c (next_cnt_c),
    .wrap_c     (wrap_c)
  );

  // Accepting speed only at the wrap keeps every period a whole, glitch-free pulse.
  assign next_duty_c = wrap_c ? bus.speed : duty;

  always_ff @(posedge clk or negedge arst) begin
    if (!arst) begin
      duty  <= WIDTH'(SPEED_OFF);
      pwm_q <= 1'b0;
    end else begin
      duty  <= next_duty_c;
      pwm_q <= (next_cnt_c < next_duty_c);
    end
  end

  assign bus.pwm_data = pwm_q;

  // Reset values (cnt all ones, duty 0) already satisfy this, so it holds from reset on.
  pwm_matches_cnt : assert property (@(posedge clk) disable iff (!arst)
    pwm_q == (cnt < duty));

endmodule : fan_speed

// File: tb/tb_fan_speed.sv
// Directed and randomised checks of the fan PWM generator, sampled on the falling edge.
module tb_fan_speed;
  import fan_speed_pkg::*;

  logic clk;
  logic arst;
  int   checks;
  int   errors;

  fan_speed_if #(.WIDTH(PWM_WIDTH)) bus ();

  fan_speed #(.WIDTH(PWM_WIDTH)) dut (
    .clk  (clk),
    .arst (arst),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [255:0] pattern(input int hi);
    logic [255:0] p;
    for (int i = 0; i < 256; i++) p[i] = (i < hi);
    return p;
  endfunction

  task automatic cycle();
    @(posedge clk);
    @(negedge clk);
  endtask

  // Records one period of output starting at the current (cnt=0) sample.
  task automatic run_period(input int change_at, input logic [7:0] new_speed,
                            output logic [255:0] seen);
    for (int i = 0; i < 256; i++) begin
      seen[i] = bus.pwm_data;
      if (i == change_at) bus.speed = new_speed;
      cycle();
    end
  endtask

  task automatic test_reset();
    logic [255:0] seen;
    arst = 1'b0;
    bus.speed = 8'hCC;
    #12;
    @(negedge clk);
    checks++;
    if (bus.pwm_data !== 1'b0) begin
      errors++;
      $display("FAIL reset_hold pwm_data=%b want 0", bus.pwm_data);
    end
    arst = 1'b1;
    cycle();
    checks++;
    if (bus.pwm_data !== 1'b1) begin
      errors++;
      $display("FAIL first_edge pwm_data=%b want 1", bus.pwm_data);
    end
    for (int p = 0; p < 2; p++) begin
      run_period(-1, 8'h00, seen);
      checks++;
      if (seen !== pattern(204)) begin
        errors++;
        $display("FAIL cc_period%0d got %h want %h", p, seen, pattern(204));
      end
    end
  endtask

  task automatic test_change_mid();
    logic [255:0] seen;
    run_period(100, 8'hEE, seen);
    checks++;
    if (seen !== pattern(204)) begin
      errors++;
      $display("FAIL change_old_period got %h want %h", seen, pattern(204));
    end
    for (int p = 0; p < 2; p++) begin
      run_period(-1, 8'h00, seen);
      checks++;
      if (seen !== pattern(238)) begin
        errors++;
        $display("FAIL ee_period%0d got %h want %h", p, seen, pattern(238));
      end
    end
  endtask

  task automatic test_zero_max();
    logic [255:0] seen;
    run_period(10, SPEED_OFF, seen);
    checks++;
    if (seen !== pattern(238)) begin
      errors++;
      $display("FAIL pre_zero_period got %h want %h", seen, pattern(238));
    end
    for (int p = 0; p < 3; p++) begin
      run_period((p == 2) ? 5 : -1, SPEED_MAX, seen);
      checks++;
      if (seen !== pattern(0)) begin
        errors++;
        $display("FAIL zero_period%0d got %h want %h", p, seen, pattern(0));
      end
    end
    for (int p = 0; p < 2; p++) begin
      run_period(-1, 8'h00, seen);
      checks++;
      if (seen !== pattern(255)) begin
        errors++;
        $display("FAIL max_period%0d got %h want %h", p, seen, pattern(255));
      end
    end
  endtask

  task automatic test_reset_mid();
    logic [255:0] seen;
    for (int i = 0; i < 50; i++) cycle();
    checks++;
    if (bus.pwm_data !== 1'b1) begin
      errors++;
      $display("FAIL pre_reset_high pwm_data=%b want 1", bus.pwm_data);
    end
    #2;
    arst = 1'b0;
    #1;
    checks++;
    if (bus.pwm_data !== 1'b0) begin
      errors++;
      $display("FAIL async_reset pwm_data=%b want 0", bus.pwm_data);
    end
    bus.speed = 8'h80;
    for (int i = 0; i < 3; i++) begin
      cycle();
      checks++;
      if (bus.pwm_data !== 1'b0) begin
        errors++;
        $display("FAIL in_reset%0d pwm_data=%b want 0", i, bus.pwm_data);
      end
    end
    arst = 1'b1;
    cycle();
    run_period(-1, 8'h00, seen);
    checks++;
    if (seen !== pattern(128)) begin
      errors++;
      $display("FAIL post_reset_period got %h want %h", seen, pattern(128));
    end
  endtask

  task automatic test_toggle();
    logic [255:0] seen;
    for (int i = 0; i < 256; i++) begin
      seen[i] = bus.pwm_data;
      bus.speed = ((i % 32) < 16) ? 8'hF0 : 8'h10;
      if (i == 255) bus.speed = 8'h10;
      cycle();
    end
    checks++;
    if (seen !== pattern(128)) begin
      errors++;
      $display("FAIL toggle_period got %h want %h", seen, pattern(128));
    end
    run_period(-1, 8'h00, seen);
    checks++;
    if (seen !== pattern(16)) begin
      errors++;
      $display("FAIL toggle_applied got %h want %h", seen, pattern(16));
    end
  endtask

  task automatic test_random();
    logic [255:0] seen;
    int cur;
    int nxt;
    cur = 16;
    for (int p = 0; p < 8; p++) begin
      nxt = int'($urandom_range(0, 255));
      run_period(int'($urandom_range(0, 255)), 8'(nxt), seen);
      checks++;
      if (seen !== pattern(cur)) begin
        errors++;
        $display("FAIL random_period%0d duty=%0d got %h want %h", p, cur, seen, pattern(cur));
      end
      cur = nxt;
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    arst = 1'b0;
    bus.speed = 8'h00;
    test_reset();
    test_change_mid();
    test_zero_max();
    test_reset_mid();
    test_toggle();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule : tb_fan_speed
